spi_ram_ctrl: RTL and testbench

Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid frames and decodes bits [9:8] as a command.
- Performs address loads, writes and reads.
- Returns read data to the slave on tx_data/tx_valid for shifting out on MISO.

---
 rtl/spi_ram_pkg.sv | 13 +
 rtl/spi_ram_array.sv | 29 ++
 rtl/spi_ram_ctrl.sv | 92 +++++++++
 tb/tb_spi_ram_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encoding and frame field positions for the SPI-attached RAM.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int CMD_MSB   = 9;
  localparam int CMD_LSB   = 8;
  localparam int PAYLOAD_W = 8;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port byte-wide memory with a registered read port.
module spi_ram_array
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [PAYLOAD_W-1:0] wdata,
  output logic [PAYLOAD_W-1:0] rdata
);

  logic [PAYLOAD_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI slave frames into address loads, writes and reads of a local RAM.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [PAYLOAD_W-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  logic                 rx_valid_d;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_addr_ok, rd_addr_ok;
  logic                 tx_valid_reg, cmd_err_reg;

  logic                 accept;
  logic [1:0]           cmd;
  logic [PAYLOAD_W-1:0] payload;
  logic                 addr_in_range;
  logic                 wr_en, rd_en, err_next;
  logic [ADDR_SIZE-1:0] wr_addr_inc, rd_addr_inc, mem_addr;

  // One command per rising edge of rx_valid, however long it is held.
  assign accept        = rx_valid & ~rx_valid_d;
  assign cmd           = rx_data[CMD_MSB:CMD_LSB];
  assign payload       = rx_data[PAYLOAD_W-1:0];
  assign addr_in_range = (int'(payload) < MEM_DEPTH);

  assign wr_en = accept && (cmd == CMD_WR_DATA) && wr_addr_ok;
  assign rd_en = accept && (cmd == CMD_RD_DATA) && rd_addr_ok;

  assign err_next = accept &&
                    ((((cmd == CMD_WR_ADDR) || (cmd == CMD_RD_ADDR)) && !addr_in_range) ||
                     ((cmd == CMD_WR_DATA) && !wr_addr_ok) ||
                     ((cmd == CMD_RD_DATA) && !rd_addr_ok));

  assign wr_addr_inc = (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_SIZE'(1);
  assign rd_addr_inc = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_SIZE'(1);
  assign mem_addr    = (cmd == CMD_RD_DATA) ? rd_addr : wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d   <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_addr_ok   <= 1'b0;
      rd_addr_ok   <= 1'b0;
      tx_valid_reg <= 1'b0;
      cmd_err_reg  <= 1'b0;
    end else begin
      rx_valid_d   <= rx_valid;
      tx_valid_reg <= rd_en;
      cmd_err_reg  <= err_next;
      if (accept && (cmd == CMD_WR_ADDR) && addr_in_range) begin
        wr_addr    <= payload[ADDR_SIZE-1:0];
        wr_addr_ok <= 1'b1;
      end
      if (accept && (cmd == CMD_RD_ADDR) && addr_in_range) begin
        rd_addr    <= payload[ADDR_SIZE-1:0];
        rd_addr_ok <= 1'b1;
      end
      if (wr_en && (AUTO_INC != 0)) wr_addr <= wr_addr_inc;
      if (rd_en && (AUTO_INC != 0)) rd_addr <= rd_addr_inc;
    end
  end

  spi_ram_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (mem_addr),
    .we   (wr_en),
    .re   (rd_en),
    .wdata(payload),
    .rdata(tx_data)
  );

  assign tx_valid = tx_valid_reg;
  assign cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Drives three controller configurations with the same frames and checks each against a behavioural model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;

  logic [7:0] tx_data [3];
  logic       tx_valid [3];
  logic       cmd_err [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .cmd_err(cmd_err[0]));

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .cmd_err(cmd_err[1]));

  spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(7), .AUTO_INC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .cmd_err(cmd_err[2]));

  // Reference model state, one slot per configuration.
  int         depth [3] = '{256, 256, 128};
  bit         inc   [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] m_mem     [3][256];
  bit         m_written [3][256];
  int         m_wa [3], m_ra [3];
  bit         m_wok [3], m_rok [3];
  logic [7:0] m_tx [3];
  bit         m_tx_known [3];
  bit         exp_tv [3], exp_err [3];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit pulse_slot);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.tx_valid[%0d]", tag, k), {7'b0, tx_valid[k]},
          pulse_slot ? {7'b0, exp_tv[k]} : 8'h00);
      chk($sformatf("%s.cmd_err[%0d]", tag, k), {7'b0, cmd_err[k]},
          pulse_slot ? {7'b0, exp_err[k]} : 8'h00);
      if (m_tx_known[k])
        chk($sformatf("%s.tx_data[%0d]", tag, k), tx_data[k], m_tx[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wa[k] = 0; m_ra[k] = 0;
      m_wok[k] = 1'b0; m_rok[k] = 1'b0;
      m_tx[k] = 8'h00; m_tx_known[k] = 1'b1;
      exp_tv[k] = 1'b0; exp_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [9:0] f);
    int p;
    p = int'(f[7:0]);
    exp_tv[k] = 1'b0;
    exp_err[k] = 1'b0;
    case (f[9:8])
      2'b00: if (p < depth[k]) begin m_wa[k] = p; m_wok[k] = 1'b1; end
             else exp_err[k] = 1'b1;
      2'b01: if (m_wok[k]) begin
               m_mem[k][m_wa[k]] = f[7:0];
               m_written[k][m_wa[k]] = 1'b1;
               if (inc[k]) m_wa[k] = (m_wa[k] + 1) % depth[k];
             end else exp_err[k] = 1'b1;
      2'b10: if (p < depth[k]) begin m_ra[k] = p; m_rok[k] = 1'b1; end
             else exp_err[k] = 1'b1;
      default: if (m_rok[k]) begin
               m_tx[k] = m_mem[k][m_ra[k]];
               m_tx_known[k] = m_written[k][m_ra[k]];
               exp_tv[k] = 1'b1;
               if (inc[k]) m_ra[k] = (m_ra[k] + 1) % depth[k];
             end else exp_err[k] = 1'b1;
    endcase
  endtask

  task automatic do_reset(input bit frame_during);
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    #1 check_all("async_rst", 1'b0);
    if (frame_during) begin
      @(negedge clk); rx_data = 10'h0_10; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check_all("post_rst", 1'b0);
    $display("reset frame_during=%0d", frame_during);
  endtask

  task automatic frame(input logic [9:0] f, input int hold);
    @(negedge clk);
    rx_data = f;
    rx_valid = 1'b1;
    for (int k = 0; k < 3; k++) model_step(k, f);
    @(negedge clk);
    check_all($sformatf("frame_%h", f), 1'b1);
    $display("frame %h hold=%0d tv=%b%b%b err=%b%b%b tx=%h/%h/%h", f, hold,
             tx_valid[0], tx_valid[1], tx_valid[2], cmd_err[0], cmd_err[1], cmd_err[2],
             tx_data[0], tx_data[1], tx_data[2]);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check_all("held", 1'b0);
    end
    rx_valid = 1'b0;
    rx_data = 10'($urandom);
    @(negedge clk);
    check_all("gap", 1'b0);
  endtask

  initial begin
    logic [7:0] pl;
    logic [1:0] c;
    do_reset(1'b0);

    // Basic write then read back.
    frame(10'h0_2A, 1);
    frame(10'h1_5C, 1);
    frame(10'h2_2A, 1);
    frame(10'h3_00, 1);
    chk("basic_rd_dut0", tx_data[0], 8'h5C);
    chk("basic_rd_dut2", tx_data[2], 8'h5C);

    // Data commands before any address load are rejected.
    do_reset(1'b1);
    frame(10'h1_11, 1);
    frame(10'h3_00, 1);
    chk("no_addr_tx_data", tx_data[0], 8'h00);

    // Level-held rx_valid yields a single read.
    frame(10'h2_2A, 1);
    frame(10'h3_00, 5);

    // Wrap at the top of memory and overwrite behaviour.
    frame(10'h0_FF, 1);
    frame(10'h1_A1, 2);
    frame(10'h1_B2, 1);
    frame(10'h2_FF, 1);
    frame(10'h3_00, 1);
    chk("wrap_first_dut1", tx_data[1], 8'hA1);
    frame(10'h3_00, 1);
    chk("wrap_second_dut1", tx_data[1], 8'hB2);
    frame(10'h2_00, 1);
    frame(10'h3_00, 1);
    chk("wrap_mem0_dut1", tx_data[1], 8'hB2);

    // Out-of-range address on the 128-word configuration.
    do_reset(1'b0);
    frame(10'h0_80, 1);
    frame(10'h1_33, 1);
    frame(10'h2_7F, 1);

    // Reset in the middle of operation drops the read address.
    do_reset(1'b0);
    frame(10'h3_00, 1);

    for (int n = 0; n < 300; n++) begin
      c = 2'($urandom_range(0, 3));
      if (c[0] == 1'b0) begin
        case ($urandom_range(0, 2))
          0:       pl = 8'($urandom_range(0, 3));
          1:       pl = 8'($urandom_range(126, 129));
          default: pl = 8'($urandom_range(252, 255));
        endcase
      end else begin
        pl = 8'($urandom);
      end
      frame({c, pl}, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
